// File: rtl/gpio_pkg_hdl.sv
// Shared helpers for the gpio responder.
//   cnt_width : width of a counter that must hold 0..n-1, never less than one bit.
//   resize_zx : zero-extends or truncates a value of src_w bits; the caller casts
//               the result down to its destination width.
package gpio_pkg_hdl;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic word_t resize_zx(input word_t v, input int src_w);
    word_t mask;
    mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < src_w) mask[i] = 1'b1;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/gpio_responder_core_if.sv
// Bus bundle between the gpio initiator and this responder.
//   write_port : initiator -> responder, asynchronous to the responder logic
//   read_port  : responder -> initiator, registered
//   evt_valid / evt_data / evt_ready : debounced-change event stream (FWFT)
// master = initiator/host side, slave = responder.
interface gpio_responder_core_if #(
  parameter int READ_PORT_WIDTH  = 4,
  parameter int WRITE_PORT_WIDTH = 4
);
  logic [WRITE_PORT_WIDTH-1:0] write_port;
  logic [READ_PORT_WIDTH-1:0]  read_port;
  logic                        evt_valid;
  logic [WRITE_PORT_WIDTH-1:0] evt_data;
  logic                        evt_ready;

  modport master (
    output write_port, evt_ready,
    input  read_port, evt_valid, evt_data
  );

  modport slave (
    input  write_port, evt_ready,
    output read_port, evt_valid, evt_data
  );
endinterface

// File: rtl/gpio_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for change events.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i        : write push_data_i (accepted unless full without a pop)
//   pop_i         : remove head when non-empty (ignored when empty)
//   valid_o       : FIFO non-empty; data_o is the head whenever valid_o=1
//   drop_o        : one-cycle pulse when a push was discarded because full
// Full/empty come from read/write pointers carrying an extra wrap bit.
module gpio_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);
  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty, full, do_pop, do_push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign valid_o = ~empty;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/gpio_responder_core.sv
// Responder end of the gpio bus.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : write_port in, read_port out, event stream evt_valid/evt_data/evt_ready
//   rd_load      : load rd_data into the read register
//   rd_data      : value for the read register
//   loopback     : 1 -> read_port follows stable_out instead of the read register
//   stable_out   : debounced write_port
//   overflow     : sticky, set when an event was dropped; cleared by overflow_clr
//   overflow_clr : clear overflow (a simultaneous new drop keeps it set)
// write_port is synchronized, then each bit is debounced independently; every
// edge where any debounced bit changes pushes the full new vector as one event.
module gpio_responder_core
  import gpio_pkg_hdl::*;
#(
  parameter int                         READ_PORT_WIDTH  = 4,
  parameter int                         WRITE_PORT_WIDTH = 4,
  parameter int                         SYNC_STAGES      = 2,
  parameter int                         DEBOUNCE_CYCLES  = 4,
  parameter int                         EVT_DEPTH        = 4,
  parameter logic [READ_PORT_WIDTH-1:0] READ_RESET       = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  gpio_responder_core_if.slave        bus,
  input  logic                        rd_load,
  input  logic [READ_PORT_WIDTH-1:0]  rd_data,
  input  logic                        loopback,
  output logic [WRITE_PORT_WIDTH-1:0] stable_out,
  output logic                        overflow,
  input  logic                        overflow_clr
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [WRITE_PORT_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WRITE_PORT_WIDTH-1:0] sync_last;
  logic [WRITE_PORT_WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]               cnt_q [WRITE_PORT_WIDTH];
  logic [CW-1:0]               cnt_d [WRITE_PORT_WIDTH];
  logic                        overflow_q, overflow_d;
  logic [READ_PORT_WIDTH-1:0]  rd_reg_q, rd_reg_d;
  logic [READ_PORT_WIDTH-1:0]  read_port_q, read_port_d;
  logic                        evt_push, evt_drop, evt_valid, evt_pop;
  logic [WRITE_PORT_WIDTH-1:0] evt_data;

  // Synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.write_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Per-bit debounce: count consecutive samples that differ from the stable
  // value; the DEBOUNCE_CYCLES-th such sample commits the new value.
  for (genvar gi = 0; gi < WRITE_PORT_WIDTH; gi++) begin : g_deb
    logic differ, at_limit;
    assign differ      = sync_last[gi] ^ stable_q[gi];
    assign at_limit    = (cnt_q[gi] == CW'(DEBOUNCE_CYCLES - 1));
    assign stable_d[gi] = (differ && at_limit) ? sync_last[gi] : stable_q[gi];
    assign cnt_d[gi]    = (!differ || at_limit) ? '0 : cnt_q[gi] + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < WRITE_PORT_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WRITE_PORT_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable_out = stable_q;

  // The event is pushed on the same edge stable_q updates, so evt_valid and
  // stable_out change together when the FIFO was empty.
  assign evt_push = (stable_d != stable_q);
  assign evt_pop  = evt_valid & bus.evt_ready;

  gpio_evt_fifo #(
    .WIDTH (WRITE_PORT_WIDTH),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (evt_push),
    .push_data_i (stable_d),
    .pop_i       (evt_pop),
    .valid_o     (evt_valid),
    .data_o      (evt_data),
    .drop_o      (evt_drop)
  );

  assign bus.evt_valid = evt_valid;
  assign bus.evt_data  = evt_data;

  // Set has priority over clear.
  assign overflow_d = evt_drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

  // Read path: register is always loadable; loopback only selects what drives out.
  assign rd_reg_d    = rd_load ? rd_data : rd_reg_q;
  assign read_port_d = loopback
                     ? READ_PORT_WIDTH'(resize_zx(word_t'(stable_q), WRITE_PORT_WIDTH))
                     : rd_reg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      rd_reg_q    <= READ_RESET;
      read_port_q <= READ_RESET;
    end else begin
      overflow_q  <= overflow_d;
      rd_reg_q    <= rd_reg_d;
      read_port_q <= read_port_d;
    end
  end

  assign overflow      = overflow_q;
  assign bus.read_port = read_port_q;

endmodule

// File: tb/tb_gpio_responder_core.sv
module tb_gpio_responder_core;
  localparam int RW = 4;
  localparam int WW = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int ED = 4;
  localparam logic [RW-1:0] RR = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_load = 1'b0;
  logic [RW-1:0] rd_data = '0;
  logic          loopback = 1'b0;
  logic          overflow_clr = 1'b0;
  logic [WW-1:0] stable_out;
  logic          overflow;

  always #5 clk = ~clk;

  gpio_responder_core_if #(.READ_PORT_WIDTH(RW), .WRITE_PORT_WIDTH(WW)) bus();

  gpio_responder_core #(
    .READ_PORT_WIDTH  (RW),
    .WRITE_PORT_WIDTH (WW),
    .SYNC_STAGES      (SS),
    .DEBOUNCE_CYCLES  (DC),
    .EVT_DEPTH        (ED),
    .READ_RESET       (RR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rd_load      (rd_load),
    .rd_data      (rd_data),
    .loopback     (loopback),
    .stable_out   (stable_out),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a sample pipeline SS deep, then per bit a run length of
  // consecutive samples disagreeing with the stable value; reaching DC flips it.
  logic [WW-1:0] m_sync [SS];
  logic [WW-1:0] m_stable;
  int            m_run [WW];
  logic [WW-1:0] exp_q [$];
  int            m_cnt;
  logic          m_ovf;
  logic [RW-1:0] m_rdreg;
  logic [RW-1:0] m_rp;

  always @(posedge clk) begin : model
    logic [WW-1:0] smp, nst;
    bit pop, drop;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = '0;
      for (int b = 0; b < WW; b++) m_run[b] = 0;
      m_stable = '0;
      exp_q.delete();
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_rdreg = RR;
      m_rp    = RR;
    end else begin
      m_rp = loopback ? RW'(m_stable) : m_rdreg;
      if (rd_load) m_rdreg = rd_data;
      smp = m_sync[SS-1];
      nst = m_stable;
      for (int b = 0; b < WW; b++) begin
        if (smp[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] >= DC) begin
            nst[b]   = smp[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = bus.write_port;
      pop  = (m_cnt > 0) && bus.evt_ready;
      drop = 1'b0;
      if (nst != m_stable) begin
        if (m_cnt < ED || pop) begin
          exp_q.push_back(nst);
          m_cnt++;
        end else begin
          drop = 1'b1;
        end
      end
      if (pop) m_cnt--;
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_stable = nst;
    end
  end

  // Monitor: compares outputs each cycle and retires events on handshake.
  always begin : monitor
    logic [WW-1:0] e;
    @(negedge clk);
    #1;
    check("stable_out", 32'(stable_out), 32'(m_stable));
    check("read_port", 32'(bus.read_port), 32'(m_rp));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("evt_valid", 32'(bus.evt_valid), 32'(m_cnt > 0));
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", 32'(bus.evt_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("event popped data=%h expected=%h", bus.evt_data, e);
        check("evt_data", 32'(bus.evt_data), 32'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input logic [WW-1:0] v);
    check("pop_value", 32'(bus.evt_data), 32'(v));
    check("pop_valid", 32'(bus.evt_valid), 32'd1);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && bus.evt_valid; i++) begin
      bus.evt_ready = 1'b1;
      tick(1);
    end
    bus.evt_ready = 1'b0;
    check("drain_empty", 32'(bus.evt_valid), 32'd0);
  endtask

  initial begin
    bus.write_port = '0;
    bus.evt_ready  = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_read_port", 32'(bus.read_port), 32'd0);
    check("rst_stable", 32'(stable_out), 32'd0);
    check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick(20);
    check("idle_stable", 32'(stable_out), 32'd0);
    check("idle_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("idle_read_port", 32'(bus.read_port), 32'd0);
    check("idle_overflow", 32'(overflow), 32'd0);

    // Latency: change appears at exactly the 6th edge.
    bus.write_port = 4'h5;
    tick(5);
    check("lat_edge5_stable", 32'(stable_out), 32'd0);
    check("lat_edge5_valid", 32'(bus.evt_valid), 32'd0);
    tick(1);
    check("lat_edge6_stable", 32'(stable_out), 32'h5);
    check("lat_edge6_valid", 32'(bus.evt_valid), 32'd1);
    check("lat_edge6_data", 32'(bus.evt_data), 32'h5);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    check("pop_once_valid", 32'(bus.evt_valid), 32'd0);

    bus.write_port = 4'h0;
    tick(8);
    drain();

    // Short glitch is rejected, one cycle longer is accepted.
    bus.write_port = 4'h1;
    tick(3);
    bus.write_port = 4'h0;
    tick(10);
    check("glitch3_stable", 32'(stable_out), 32'd0);
    check("glitch3_valid", 32'(bus.evt_valid), 32'd0);
    bus.write_port = 4'h1;
    tick(4);
    bus.write_port = 4'h0;
    tick(2);
    check("glitch4_stable", 32'(stable_out), 32'h1);
    check("glitch4_valid", 32'(bus.evt_valid), 32'd1);
    check("glitch4_data", 32'(bus.evt_data), 32'h1);
    tick(10);
    drain();

    // Overflow: five events into a four-deep FIFO.
    for (int v = 1; v <= 5; v++) begin
      bus.write_port = WW'(v);
      tick(8);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) pop_expect(WW'(k));
    check("ovf_empty", 32'(bus.evt_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Read register and loopback.
    rd_data = 4'h9;
    rd_load = 1'b1;
    tick(1);
    rd_load = 1'b0;
    tick(1);
    check("rd_load", 32'(bus.read_port), 32'h9);
    loopback = 1'b1;
    tick(1);
    check("loopback_on", 32'(bus.read_port), 32'h5);
    loopback = 1'b0;
    tick(1);
    check("loopback_off", 32'(bus.read_port), 32'h9);

    // Reset with events queued.
    bus.write_port = 4'h6;
    tick(8);
    bus.write_port = 4'h7;
    tick(8);
    check("preq_valid", 32'(bus.evt_valid), 32'd1);
    rst = 1'b1;
    bus.write_port = 4'h0;
    tick(1);
    rst = 1'b0;
    check("midrst_valid", 32'(bus.evt_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_read_port", 32'(bus.read_port), 32'(RR));
    tick(20);
    check("postrst_valid", 32'(bus.evt_valid), 32'd0);
    check("postrst_stable", 32'(stable_out), 32'd0);

    // Randomized traffic checked by the monitor against the model.
    for (int it = 0; it < 250; it++) begin
      int hold;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      bus.write_port = WW'($urandom);
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        bus.evt_ready = ($urandom_range(0, 2) == 0);
        rd_load       = ($urandom_range(0, 5) == 0);
        rd_data       = RW'($urandom);
        if ($urandom_range(0, 7) == 0) loopback = ~loopback;
        overflow_clr  = ($urandom_range(0, 9) == 0);
        tick(1);
      end
    end
    rd_load = 1'b0;
    overflow_clr = 1'b0;
    bus.evt_ready = 1'b1;
    tick(30);
    check("final_empty", 32'(bus.evt_valid), 32'd0);
    bus.evt_ready = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
